// File: rtl/cpu_pkg.sv
// Shared CPU constants and word types
// used by fetch, ROM and decode.
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int INSN_W = 15;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INSN_W-1:0] insn_t;

  localparam addr_t RESET_PC = '0;
endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched
// word and its pc, with a valid flag.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  push,
  input  logic  pop,
  input  insn_t d,
  input  addr_t d_pc,
  output insn_t q,
  output addr_t q_pc,
  output logic  valid
);
  insn_t q_q, q_d;
  addr_t pc_q, pc_d;
  logic  valid_q, valid_d;

  always_comb begin
    q_d     = q_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (push) begin
      q_d  = d;
      pc_d = d_pc;
    end
    if (flush)     valid_d = 1'b0;
    else if (push) valid_d = 1'b1;
    else if (pop)  valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign q     = q_q;
  assign q_pc  = pc_q;
  assign valid = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the pc, tracks the
// in-flight ROM read and buffers up to 2 words.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  output addr_t rom_addr,
  input  insn_t rom_q,
  input  logic  redirect,
  input  addr_t redirect_pc,
  output logic  ir_valid,
  output insn_t ir,
  output addr_t ir_pc,
  input  logic  ir_ready
);
  addr_t pc_q, pc_d;
  logic  inflight_q, inflight_d;
  addr_t inflight_pc_q, inflight_pc_d;
  insn_t ir_q, ir_d;
  addr_t ir_pc_q, ir_pc_d;
  logic  ir_valid_q, ir_valid_d;

  insn_t skid_q;
  addr_t skid_pc;
  logic  skid_valid;

  logic       transfer;
  logic       issue;
  logic       to_ir;
  logic       skid_push;
  logic       skid_pop;
  logic [1:0] occ;

  always_comb begin
    transfer = ir_valid_q & ir_ready;
    occ = {1'b0, ir_valid_q}
        + {1'b0, skid_valid}
        + {1'b0, inflight_q}
        - {1'b0, transfer};
    issue = !redirect && (occ < 2'd2);
    // returning word bypasses the skid only
    // when nothing older is waiting ahead of it
    to_ir = inflight_q
          & (!ir_valid_q | transfer)
          & !skid_valid;
    skid_push = inflight_q & !to_ir;
    skid_pop  = transfer & skid_valid;

    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d          = pc_q + 1'b1;
      inflight_pc_d = pc_q;
    end

    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (skid_pop) begin
      ir_d       = skid_q;
      ir_pc_d    = skid_pc;
      ir_valid_d = 1'b1;
    end else if (to_ir) begin
      ir_d       = rom_q;
      ir_pc_d    = inflight_pc_q;
      ir_valid_d = 1'b1;
    end else if (transfer) begin
      ir_valid_d = 1'b0;
    end
    if (redirect) ir_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      ir_q          <= '0;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
    end
  end

  fetch_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (skid_push),
    .pop   (skid_pop),
    .d     (rom_q),
    .d_pc  (inflight_pc_q),
    .q     (skid_q),
    .q_pc  (skid_pc),
    .valid (skid_valid)
  );

  assign rom_addr = pc_q;
  assign ir_valid = ir_valid_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
endmodule
